onehot_encoder: RTL and testbench

Registered 8-to-3 one-hot encoder: the reverse of the 3-to-8 one-hot decoder that drives the LED outputs. It synchronises and debounces an 8-bit one-hot input bus, such as the switch bank or the decoder output looped back for self-check. Each stable value is checked for one-hot validity. Valid values are encoded to a 3-bit index with a change strobe; invalid values raise an error flag and bump a saturating error counter.

---
 rtl/onehot_encoder.sv | 95 +++++++++
 tb/tb_onehot_encoder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/onehot_encoder.sv
// rtl/onehot_encoder.sv - registered 8-to-3 one-hot encoder with sync, debounce and error counting
module onehot_encoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] onehot_in,
    input  logic       clr_err,
    output logic [2:0] code_out,
    output logic       code_valid,
    output logic       code_strobe,
    output logic       err,
    output logic [7:0] err_count
);

    localparam int CNT_W = ($clog2(STABLE_CYCLES + 1) < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [7:0]       sync1;
    logic [7:0]       sync2;
    logic [7:0]       cand;
    logic [CNT_W-1:0] cnt;
    logic             done;

    logic [3:0] ones;
    logic [2:0] idx;
    logic       is_onehot;
    logic       accept;

    always_comb begin
        ones = 4'd0;
        idx  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (cand[i]) begin
                ones = ones + 4'd1;
                idx  = 3'(i);
            end
        end
        is_onehot = (ones == 4'd1);
        // An input change in the acceptance cycle wins: the candidate restarts instead.
        accept = (sync2 == cand) && !done && (cnt == CNT_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1       <= 8'd0;
            sync2       <= 8'd0;
            cand        <= 8'd0;
            cnt         <= '0;
            done        <= 1'b1;
            code_out    <= 3'd0;
            code_valid  <= 1'b0;
            code_strobe <= 1'b0;
            err         <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            sync1       <= onehot_in;
            sync2       <= sync1;
            code_strobe <= 1'b0;

            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= '0;
                done <= 1'b0;
            end else if (accept) begin
                done <= 1'b1;
            end else if (!done) begin
                cnt <= cnt + CNT_ONE;
            end

            if (accept && is_onehot) begin
                code_out    <= idx;
                code_valid  <= 1'b1;
                err         <= 1'b0;
                code_strobe <= !code_valid || (idx != code_out);
            end else if (accept) begin
                code_valid <= 1'b0;
                err        <= 1'b1;
            end

            // A clear coinciding with an invalid acceptance still counts that acceptance.
            if (accept && !is_onehot) begin
                if (clr_err) begin
                    err_count <= 8'd1;
                end else if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end else if (clr_err) begin
                err_count <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_onehot_encoder.sv
// tb/tb_onehot_encoder.sv - scoreboard bench for onehot_encoder
module tb_onehot_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] onehot_in = 8'd0;
    logic       clr_err = 1'b0;
    logic [2:0] code_out;
    logic       code_valid;
    logic       code_strobe;
    logic       err;
    logic [7:0] err_count;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         at;
        logic [2:0] code;
        logic       valid;
        logic       strobe;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    exp_t        q[$];
    logic [12:0] prev_exp = 13'd0;

    onehot_encoder #(.STABLE_CYCLES(4)) dut (
        .clk(clk),
        .rst(rst),
        .onehot_in(onehot_in),
        .clr_err(clr_err),
        .code_out(code_out),
        .code_valid(code_valid),
        .code_strobe(code_strobe),
        .err(err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Queue an expected output event only when something observable should change.
    task automatic expect_ev(input int at, input logic [2:0] c, input logic v, input logic s,
                             input logic e, input logic [7:0] n);
        exp_t x;
        if (s || {c, v, e, n} != prev_exp) begin
            x = '{at, c, v, s, e, n};
            q.push_back(x);
        end
        prev_exp = {c, v, e, n};
    endtask

    task automatic settle(input logic [7:0] v, input logic [2:0] c, input logic vl, input logic s,
                          input logic e, input logic [7:0] n, input bit with_clr);
        onehot_in = v;
        expect_ev(cyc + 7, c, vl, s, e, n);
        if (with_clr) begin
            tick(6);
            clr_err = 1'b1;
            tick(1);
            clr_err = 1'b0;
            tick(2);
        end else begin
            tick(9);
        end
    endtask

    task automatic glitch(input logic [7:0] v, input int n, input logic [7:0] back);
        onehot_in = v;
        tick(n);
        onehot_in = back;
        tick(10);
    endtask

    initial begin : monitor
        exp_t        x;
        logic [12:0] obs;
        logic [12:0] prev_obs;
        prev_obs = 13'd0;
        forever begin
            @(negedge clk);
            obs = {code_out, code_valid, err, err_count};
            if (code_strobe || obs !== prev_obs) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got code=%0d valid=%0d strobe=%0d err=%0d cnt=%0d with nothing expected at cycle %0d",
                             code_out, code_valid, code_strobe, err, err_count, cyc);
                end else begin
                    x = q.pop_front();
                    chk("event_cycle", cyc, x.at);
                    chk("code_out", int'(code_out), int'(x.code));
                    chk("code_valid", int'(code_valid), int'(x.valid));
                    chk("code_strobe", int'(code_strobe), int'(x.strobe));
                    chk("err", int'(err), int'(x.err));
                    chk("err_count", int'(err_count), int'(x.cnt));
                end
            end
            prev_obs = obs;
        end
    end

    initial begin : stimulus
        tick(3);
        rst = 1'b0;
        tick(20);
        chk("reset_code_out", int'(code_out), 0);
        chk("reset_code_valid", int'(code_valid), 0);
        chk("reset_code_strobe", int'(code_strobe), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_err_count", int'(err_count), 0);

        settle(8'h20, 3'd5, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
        glitch(8'h08, 2, 8'h20);
        settle(8'h08, 3'd3, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);

        settle(8'h03, 3'd3, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0);
        settle(8'h00, 3'd3, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0);
        settle(8'h80, 3'd7, 1'b1, 1'b1, 1'b0, 8'd2, 1'b0);

        for (int k = 0; k < 300; k++) begin
            settle((k % 2 == 1) ? 8'h05 : 8'h03, 3'd7, 1'b0, 1'b0, 1'b1,
                   (k + 3 > 255) ? 8'd255 : 8'(k + 3), 1'b0);
        end
        chk("saturated_err_count", int'(err_count), 255);

        clr_err = 1'b1;
        expect_ev(cyc + 1, 3'd7, 1'b0, 1'b0, 1'b1, 8'd0);
        tick(1);
        clr_err = 1'b0;
        tick(3);
        settle(8'h03, 3'd7, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1);

        onehot_in = 8'h10;
        tick(5);
        expect_ev(cyc, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        rst = 1'b1;
        #1;
        chk("midrst_code_out", int'(code_out), 0);
        chk("midrst_code_valid", int'(code_valid), 0);
        chk("midrst_err", int'(err), 0);
        chk("midrst_err_count", int'(err_count), 0);
        tick(2);
        rst = 1'b0;
        expect_ev(cyc + 7, 3'd4, 1'b1, 1'b1, 1'b0, 8'd0);
        tick(12);

        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
